memory_arbiter: RTL and testbench

- Shares the single SDRAM controller port between NUM_PORTS requesters, e.g. N64 PI, USB bridge and SD DMA.
- Selects one request per cycle, round-robin.
- Tracks outstanding reads in an in-order ID FIFO and routes each returning read ack and data to the port that issued the read.
- Sits between the requesters and the SDRAM controller's request/busy/ack interface.

---
 rtl/memory_arbiter.sv | 110 +++++++++++
 tb/tb_memory_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin SDRAM port sharing with in-order read-ID return routing; optional MEMORY_ARBITER_PORT0_PRIORITY_EN gives port 0 absolute priority
module memory_arbiter #(
  parameter int NUM_PORTS     = 3,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_PORTS-1:0]     i_req,
  input  logic [NUM_PORTS-1:0]     i_write,
  input  logic [25*NUM_PORTS-1:0]  i_address,
  input  logic [32*NUM_PORTS-1:0]  i_data,
  output logic [NUM_PORTS-1:0]     o_busy,
  output logic [NUM_PORTS-1:0]     o_ack,
  output logic [31:0]              o_data,
  output logic                     o_mem_request,
  output logic                     o_mem_write,
  output logic [24:0]              o_mem_address,
  output logic [31:0]              o_mem_data,
  input  logic                     i_mem_busy,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_data,
  output logic                     o_error
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(ID_FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [PW-1:0]        rr_q, rr_d, sel;
  logic [PW-1:0]        fifo_q [ID_FIFO_DEPTH];
  logic [PW-1:0]        fifo_d [ID_FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d, elig;
  logic [31:0]          data_q, data_d;
  logic                 err_q, err_d, found, accept, push, pop;
  int                   idx;
  // pick the first eligible port starting at rr_q; reads need a free ID slot
  always_comb begin
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    elig  = i_req & (i_write | {NUM_PORTS{cnt_q != CW'(ID_FIFO_DEPTH)}});
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      idx = idx >= NUM_PORTS ? idx - NUM_PORTS : idx;
      if (elig[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
    if (elig[0]) begin
      found = 1'b1;
      sel   = '0;
    end
`endif
  end
  // drive the memory port from the selected requester and stall everyone else
  always_comb begin
    o_mem_request = found;
    o_mem_write   = found & i_write[sel];
    o_mem_address = found ? i_address[25*int'(sel) +: 25] : '0;
    o_mem_data    = found ? i_data[32*int'(sel) +: 32] : '0;
    o_busy        = '0;
    for (int n = 0; n < NUM_PORTS; n++)
      o_busy[n] = i_req[n] & ((found && sel == PW'(n)) ? i_mem_busy : 1'b1);
  end
  // next state: pointer advance, read-ID push/pop, ack routing, sticky error
  always_comb begin
    accept = found & ~i_mem_busy;
    push   = accept & ~i_write[sel];
    pop    = i_mem_ack & (cnt_q != '0);
    rr_d   = !accept ? rr_q : (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
    rr_d   = (accept && sel == '0) ? rr_q : rr_d;
`endif
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = sel;
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    ack_d  = pop ? NUM_PORTS'(1) << fifo_q[rd_q] : '0;
    data_d = pop ? i_mem_data : data_q;
    err_d  = err_q | (i_mem_ack & ~pop);
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_q   <= '0;
      fifo_q <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ack_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      fifo_q <= fifo_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end
  assign o_ack   = ack_q;
  assign o_data  = data_q;
  assign o_error = err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter (honours MEMORY_ARBITER_PORT0_PRIORITY_EN)
module tb_memory_arbiter;
  localparam int NP = 3;
  localparam int D  = 4;
  typedef struct {int port; logic [31:0] data;} ack_t;
  logic          i_clk = 1'b0, i_reset_n = 1'b0;
  logic [NP-1:0] i_req = '0, i_write = '0;
  logic [74:0]   i_address = {25'h0000300, 25'h0000100, 25'h0000040};
  logic [95:0]   i_data = {32'h0BADF00D, 32'h12345678, 32'hA5A50000};
  logic          i_mem_busy = 1'b0, i_mem_ack = 1'b0;
  logic [31:0]   i_mem_data = '0;
  logic [NP-1:0] o_busy, o_ack;
  logic [31:0]   o_data, o_mem_data;
  logic          o_mem_request, o_mem_write, o_error;
  logic [24:0]   o_mem_address;
  int            checks = 0, errors = 0, m_rr = 0, m_cnt = 0;
  logic          m_err = 1'b0;
  bit            mon_en = 1'b0;
  int            issued[$];
  ack_t          exp_q[$];
  ack_t          e;

  memory_arbiter #(.NUM_PORTS(NP), .ID_FIFO_DEPTH(D)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_write(i_write),
    .i_address(i_address), .i_data(i_data), .o_busy(o_busy), .o_ack(o_ack),
    .o_data(o_data), .o_mem_request(o_mem_request), .o_mem_write(o_mem_write),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data), .i_mem_busy(i_mem_busy),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [24:0] addr_of(input int n);
    return n < 0 ? 25'h0 : i_address[25*n +: 25];
  endfunction

  function automatic logic [31:0] data_of(input int n);
    return n < 0 ? 32'h0 : i_data[32*n +: 32];
  endfunction

  function automatic int model_sel(input logic [NP-1:0] req, input logic [NP-1:0] wr);
    int s = -1;
    for (int k = NP - 1; k >= 0; k--) begin
      int j = (m_rr + k) % NP;
      if (req[j] && (wr[j] || m_cnt < D)) s = j;
    end
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
    if (req[0] && (wr[0] || m_cnt < D)) s = 0;
`endif
    return s;
  endfunction

  task automatic cycle(input logic [NP-1:0] req, input logic [NP-1:0] wr,
                       input logic mb, input logic ma, input logic [31:0] md);
    int s, pre;
    logic [NP-1:0] eb;
    i_req = req; i_write = wr; i_mem_busy = mb; i_mem_ack = ma; i_mem_data = md;
    @(negedge i_clk);
    s  = model_sel(req, wr);
    eb = req;
    if (s >= 0 && !mb) eb[s] = 1'b0;
    check("busy", 64'(o_busy), 64'(eb));
    check("mem_req", 64'(o_mem_request), 64'(s >= 0));
    check("mem_addr", 64'(o_mem_address), 64'(addr_of(s)));
    check("mem_write", 64'(o_mem_write), 64'(s >= 0 && wr[s]));
    check("mem_data", 64'(o_mem_data), 64'(data_of(s)));
    check("error", 64'(o_error), 64'(m_err));
    @(posedge i_clk);
    pre = m_cnt;
    if (s >= 0 && !mb) begin
      if (!wr[s]) begin
        issued.push_back(s);
        m_cnt++;
      end
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
      if (s != 0) m_rr = (s + 1) % NP;
`else
      m_rr = (s + 1) % NP;
`endif
    end
    if (ma) begin
      if (pre == 0) m_err = 1'b1;
      else begin
        exp_q.push_back('{port: issued.pop_front(), data: md});
        m_cnt--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0; i_req = '0; i_write = '0; i_mem_busy = 1'b0; i_mem_ack = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    check("rst_ack", 64'(o_ack), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_error", 64'(o_error), 64'(0));
    m_rr = 0; m_cnt = 0; m_err = 1'b0;
    issued.delete();
    exp_q.delete();
    mon_en = 1'b1;
    i_reset_n = 1'b1;
  endtask

  // every cycle: the ack due now must appear with its data, otherwise no ack at all
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack", 64'(o_ack), 64'(1) << e.port);
        check("ack_data", 64'(o_data), 64'(e.data));
      end else check("no_ack", 64'(o_ack), 64'(0));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    cycle(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    // all ports read: grants 0,1,2,0 then FIFO full stalls everyone
    repeat (5) cycle(3'b111, 3'b000, 1'b0, 1'b0, 32'h0);
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'h11111111);
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'h22222222);
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'h33333333);
    cycle(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    // port 1 write stalled three cycles by the controller
    repeat (3) cycle(3'b010, 3'b010, 1'b1, 1'b0, 32'h0);
    cycle(3'b010, 3'b010, 1'b0, 1'b0, 32'h0);
    // rr now at 2: port 2 read goes first, then fill the FIFO
    repeat (4) cycle(3'b111, 3'b000, 1'b0, 1'b0, 32'h0);
    // full: port 0 write passes, port 2 read waits for a freed slot
    cycle(3'b101, 3'b001, 1'b0, 1'b0, 32'h0);
    cycle(3'b100, 3'b000, 1'b0, 1'b1, 32'h44444444);
    cycle(3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    // push and pop in the same cycle
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'h55555555);
    cycle(3'b010, 3'b000, 1'b0, 1'b1, 32'h66666666);
    while (m_cnt > 0) cycle(3'b000, 3'b000, 1'b0, 1'b1, $urandom);
    // ack with empty FIFO sets a sticky error
    cycle(3'b000, 3'b000, 1'b0, 1'b1, 32'h77777777);
    repeat (2) cycle(3'b001, 3'b001, 1'b0, 1'b0, 32'h0);
    // reset with reads outstanding drops them
    cycle(3'b011, 3'b000, 1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (3) cycle(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
    repeat (3) cycle(3'b011, 3'b011, 1'b0, 1'b0, 32'h0);
    cycle(3'b010, 3'b010, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(3'b111, 3'b000, 1'b0, 1'b0, 32'h0);
    while (m_cnt > 0) cycle(3'b000, 3'b000, 1'b0, 1'b1, $urandom);
`endif
    // random traffic exercises pointer wrap and mixed stalls
    repeat (300) cycle(NP'($urandom), NP'($urandom), ($urandom % 4) == 0,
                       m_cnt > 0 && ($urandom % 2) == 1, $urandom);
    while (m_cnt > 0) cycle(3'b000, 3'b000, 1'b0, 1'b1, $urandom);
    cycle(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
